// File: rtl/sequenciador_ciclo.sv
// ============================================================================
// sequenciador_ciclo
// ----------------------------------------------------------------------------
// Multi-cycle instruction sequencer for the CPU core. It owns the program
// counter, strobes the instruction register, waits out the instruction-memory
// read latency and turns the decoder's write requests into one-cycle execute
// pulses. It also parks the core while an IN or OUT handshake is pending, and
// on HLT.
//
// Optional feature macro: SEQ_RESUME_EN
//   defined   -> input `continuar` exists; PARADO resumes at PC+1 when it is 1
//   undefined -> no `continuar` port; only reset leaves PARADO
//
// Parameters
//   ADDR_W   PC / instruction-memory address width (default 10)
//   LAT_MEM  cycles spent in DECOD, legal 1..15 (default 1). Values outside
//            that range are clamped to the nearest legal value.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   OP                  opcode of the current IR (IN=24, OUT=25)
//   PCflag              00 next, 01 jump, 10 halt, 11 behaves as 00
//   endereco            jump target, only the low ADDR_W bits are used
//   writeReg_in         decoder register-bank write request
//   writeRAMdados_in    decoder data-RAM write request
//   writeRAMsaida_in    decoder output-RAM write request
//   NZenable_in         decoder NZ flag update request
//   entrada_valida      external input confirmed (IN handshake)
//   saida_ack           external display accepted the output (OUT handshake)
//   continuar           resume from halt (SEQ_RESUME_EN builds only)
//   PC                  program counter
//   IRload              load instruction register
//   writeReg            gated register-bank write
//   writeRAMdados       gated data-RAM write
//   writeRAMsaida       gated output-RAM write
//   NZload              gated NZ flip-flop enable
//   entrada_pronta      core is waiting for input
//   halted              core is in PARADO
//   estado              FSM state, exposed for debug
//
// Handshakes (both behave as valid/ready pairs sampled on the rising edge):
//   IN : entrada_pronta is the core's "ready" and entrada_valida the
//        environment's "valid". A transfer happens on the edge where both are
//        1; in that same cycle writeReg is pulsed so the register bank
//        captures the input word, and the PC advances.
//   OUT: the writeRAMsaida pulse in EXEC plays the role of "valid"; the core
//        then holds in ESP_OUT until saida_ack ("ready/accepted") is seen.
//        An ack that is already high during EXEC does not count, so every
//        OUT waits for an acknowledge given after the data was written.
// ============================================================================
module sequenciador_ciclo #(
    parameter int ADDR_W  = 10,
    parameter int LAT_MEM = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [4:0]        OP,
    input  logic [1:0]        PCflag,
    input  logic [31:0]       endereco,
    input  logic              writeReg_in,
    input  logic              writeRAMdados_in,
    input  logic              writeRAMsaida_in,
    input  logic              NZenable_in,
    input  logic              entrada_valida,
    input  logic              saida_ack,
`ifdef SEQ_RESUME_EN
    input  logic              continuar,
`endif
    output logic [ADDR_W-1:0] PC,
    output logic              IRload,
    output logic              writeReg,
    output logic              writeRAMdados,
    output logic              writeRAMsaida,
    output logic              NZload,
    output logic              entrada_pronta,
    output logic              halted,
    output logic [2:0]        estado
);

    // ------------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        BUSCA   = 3'd0,
        DECOD   = 3'd1,
        EXEC    = 3'd2,
        ESP_IN  = 3'd3,
        ESP_OUT = 3'd4,
        PARADO  = 3'd5
    } estadoT;

    localparam logic [4:0] OP_IN  = 5'd24;
    localparam logic [4:0] OP_OUT = 5'd25;

    localparam logic [1:0] PC_JUMP = 2'b01;
    localparam logic [1:0] PC_HALT = 2'b10;

    // DECOD is left when the down-counter reaches zero, so it is preloaded
    // with LAT_MEM-1 while in BUSCA; LAT_MEM=1 therefore gives one DECOD cycle.
    localparam int LAT_CLAMP = (LAT_MEM < 1)  ? 1  :
                               (LAT_MEM > 15) ? 15 : LAT_MEM;
    localparam logic [3:0] LAT_LOAD = 4'(LAT_CLAMP - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    estadoT            estadoAtual;
    estadoT            estadoProx;
    logic [ADDR_W-1:0] pcProx;
    logic [ADDR_W-1:0] pcMaisUm;
    logic [ADDR_W-1:0] pcSalto;
    logic [3:0]        contLat;
    logic [3:0]        contLatProx;
    logic              opEhIn;
    logic              opEhOut;

    // Natural ADDR_W-bit overflow gives the max -> 0 wrap.
    assign pcMaisUm = PC + ADDR_W'(1);

    // Jump targets wider than the PC are truncated without complaint.
    assign pcSalto  = endereco[ADDR_W-1:0];

    generate
        if (ADDR_W < 32) begin : gDescarte
            logic unusedEnderecoAlto;
            assign unusedEnderecoAlto = ^endereco[31:ADDR_W];
        end
    endgenerate

    assign opEhIn  = (OP == OP_IN);
    assign opEhOut = (OP == OP_OUT);

    assign estado  = estadoAtual;

    // ------------------------------------------------------------------------
    // Process 1: state register, PC and latency counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            estadoAtual <= BUSCA;
            PC          <= '0;
            contLat     <= '0;
        end else begin
            estadoAtual <= estadoProx;
            PC          <= pcProx;
            contLat     <= contLatProx;
        end
    end

    // ------------------------------------------------------------------------
    // Process 2: next state, next PC, next counter value
    // ------------------------------------------------------------------------
    always_comb begin
        estadoProx  = estadoAtual;
        pcProx      = PC;
        contLatProx = contLat;

        case (estadoAtual)
            BUSCA: begin
                contLatProx = LAT_LOAD;
                estadoProx  = DECOD;
            end

            DECOD: begin
                if (contLat == 4'd0) begin
                    estadoProx = EXEC;
                end else begin
                    contLatProx = contLat - 4'd1;
                end
            end

            EXEC: begin
                if (opEhIn) begin
                    // PC is advanced only once the input has been accepted.
                    estadoProx = ESP_IN;
                end else if (opEhOut) begin
                    // saida_ack is deliberately not looked at here.
                    estadoProx = ESP_OUT;
                end else if (PCflag == PC_JUMP) begin
                    pcProx     = pcSalto;
                    estadoProx = BUSCA;
                end else if (PCflag == PC_HALT) begin
                    estadoProx = PARADO;
                end else begin
                    // 00 and the unused 11 both mean "next instruction";
                    // unknown opcodes arrive here as NOPs.
                    pcProx     = pcMaisUm;
                    estadoProx = BUSCA;
                end
            end

            ESP_IN: begin
                if (entrada_valida) begin
                    pcProx     = pcMaisUm;
                    estadoProx = BUSCA;
                end
            end

            ESP_OUT: begin
                if (saida_ack) begin
                    pcProx     = pcMaisUm;
                    estadoProx = BUSCA;
                end
            end

            PARADO: begin
`ifdef SEQ_RESUME_EN
                if (continuar) begin
                    pcProx     = pcMaisUm;
                    estadoProx = BUSCA;
                end
`else
                // Only reset leaves PARADO in this build.
                estadoProx = PARADO;
`endif
            end

            default: begin
                // Encodings 6 and 7 cannot be reached; recover by refetching.
                estadoProx = BUSCA;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Process 3: outputs
    // ------------------------------------------------------------------------
    // Outputs are forced low while reset is asserted so that a reset arriving
    // in the middle of EXEC or a handshake never lets a write slip through.
    always_comb begin
        IRload         = 1'b0;
        writeReg       = 1'b0;
        writeRAMdados  = 1'b0;
        writeRAMsaida  = 1'b0;
        NZload         = 1'b0;
        entrada_pronta = 1'b0;
        halted         = 1'b0;

        if (!reset) begin
            case (estadoAtual)
                BUSCA: begin
                    IRload = 1'b1;
                end

                EXEC: begin
                    // IN writes its register later, in the accept cycle.
                    if (!opEhIn) begin
                        writeReg      = writeReg_in;
                        writeRAMdados = writeRAMdados_in;
                        writeRAMsaida = writeRAMsaida_in;
                        NZload        = NZenable_in;
                    end
                end

                ESP_IN: begin
                    entrada_pronta = 1'b1;
                    writeReg       = entrada_valida;
                end

                PARADO: begin
                    halted = 1'b1;
                end

                default: begin
                    // DECOD, ESP_OUT and unreachable codes drive nothing.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequenciador_ciclo.sv
module tb_sequenciador_ciclo;

    logic        clock;
    logic        reset;
    logic [4:0]  OP;
    logic [1:0]  PCflag;
    logic [31:0] endereco;
    logic        writeReg_in;
    logic        writeRAMdados_in;
    logic        writeRAMsaida_in;
    logic        NZenable_in;
    logic        entrada_valida;
    logic        saida_ack;
`ifdef SEQ_RESUME_EN
    logic        continuar;
`endif

    logic [9:0]  PC;
    logic        IRload, writeReg, writeRAMdados, writeRAMsaida, NZload;
    logic        entrada_pronta, halted;
    logic [2:0]  estado;

    logic [9:0]  PC3;
    logic        IRload3, writeReg3, writeRAMdados3, writeRAMsaida3, NZload3;
    logic        entrada_pronta3, halted3;
    logic [2:0]  estado3;

    int nCompared   = 0;
    int nMismatched = 0;
    int outPulses   = 0;
    int pulseBase   = 0;

    // LAT_MEM = 1 instance: target of most steps.
    sequenciador_ciclo #(.ADDR_W(10), .LAT_MEM(1)) dut (
        .clock(clock), .reset(reset), .OP(OP), .PCflag(PCflag),
        .endereco(endereco), .writeReg_in(writeReg_in),
        .writeRAMdados_in(writeRAMdados_in), .writeRAMsaida_in(writeRAMsaida_in),
        .NZenable_in(NZenable_in), .entrada_valida(entrada_valida),
        .saida_ack(saida_ack),
`ifdef SEQ_RESUME_EN
        .continuar(continuar),
`endif
        .PC(PC), .IRload(IRload), .writeReg(writeReg),
        .writeRAMdados(writeRAMdados), .writeRAMsaida(writeRAMsaida),
        .NZload(NZload), .entrada_pronta(entrada_pronta), .halted(halted),
        .estado(estado)
    );

    // LAT_MEM = 3 instance sharing the same inputs.
    sequenciador_ciclo #(.ADDR_W(10), .LAT_MEM(3)) dut3 (
        .clock(clock), .reset(reset), .OP(OP), .PCflag(PCflag),
        .endereco(endereco), .writeReg_in(writeReg_in),
        .writeRAMdados_in(writeRAMdados_in), .writeRAMsaida_in(writeRAMsaida_in),
        .NZenable_in(NZenable_in), .entrada_valida(entrada_valida),
        .saida_ack(saida_ack),
`ifdef SEQ_RESUME_EN
        .continuar(continuar),
`endif
        .PC(PC3), .IRload(IRload3), .writeReg(writeReg3),
        .writeRAMdados(writeRAMdados3), .writeRAMsaida(writeRAMsaida3),
        .NZload(NZload3), .entrada_pronta(entrada_pronta3), .halted(halted3),
        .estado(estado3)
    );

    // Clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Counts output-RAM write pulses of the LAT_MEM=1 instance.
    always @(posedge clock) begin
        if (writeRAMsaida === 1'b1) outPulses++;
    end

    // Driver tasks
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Checker
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("check %s mismatched", tag);
        end
    endtask

    initial begin
        reset            = 1'b1;
        OP               = 5'd0;
        PCflag           = 2'b00;
        endereco         = 32'd0;
        writeReg_in      = 1'b0;
        writeRAMdados_in = 1'b0;
        writeRAMsaida_in = 1'b0;
        NZenable_in      = 1'b0;
        entrada_valida   = 1'b0;
        saida_ack        = 1'b0;
`ifdef SEQ_RESUME_EN
        continuar        = 1'b0;
`endif

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_estado", 32'(estado), 32'd0);
        chk("rst_pc", 32'(PC), 32'd0);
        chk("rst_irload", 32'(IRload), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_pc_lat3", 32'(PC3), 32'd0);

        // ---------------- ADD, repeated: LAT_MEM 1 and 3 timing ----------------
        OP          = 5'd1;
        PCflag      = 2'b00;
        writeReg_in = 1'b1;
        NZenable_in = 1'b1;
        reset       = 1'b0;
        settle();                                   // cycle 0
        chk("c0_irload", 32'(IRload), 32'd1);
        chk("c0_writereg", 32'(writeReg), 32'd0);
        step();                                     // cycle 1
        chk("c1_estado", 32'(estado), 32'd1);
        chk("c1_irload", 32'(IRload), 32'd0);
        step();                                     // cycle 2
        chk("c2_estado", 32'(estado), 32'd2);
        chk("c2_writereg", 32'(writeReg), 32'd1);
        chk("c2_nzload", 32'(NZload), 32'd1);
        chk("c2_wrdados", 32'(writeRAMdados), 32'd0);
        chk("c2_lat3_estado", 32'(estado3), 32'd1);
        chk("c2_lat3_writereg", 32'(writeReg3), 32'd0);
        step();                                     // cycle 3
        chk("c3_pc", 32'(PC), 32'd1);
        chk("c3_estado", 32'(estado), 32'd0);
        chk("c3_lat3_estado", 32'(estado3), 32'd1);
        step();                                     // cycle 4
        chk("c4_lat3_estado", 32'(estado3), 32'd2);
        chk("c4_lat3_writereg", 32'(writeReg3), 32'd1);
        chk("c4_lat3_pc", 32'(PC3), 32'd0);
        step();                                     // cycle 5
        chk("c5_lat3_pc", 32'(PC3), 32'd1);
        repeat (4) step();                          // cycle 9
        chk("c9_pc", 32'(PC), 32'd3);
        chk("c9_lat3_pc", 32'(PC3), 32'd1);
        step();                                     // cycle 10
        chk("c10_lat3_pc", 32'(PC3), 32'd2);
        chk("c10_lat3_estado", 32'(estado3), 32'd0);

        // ---------------- JUMPI to 0x3FF, then wrap ----------------
        reset = 1'b1;
        step();
        reset       = 1'b0;
        OP          = 5'd14;
        PCflag      = 2'b01;
        endereco    = 32'hABCD_F7FF;
        writeReg_in = 1'b0;
        NZenable_in = 1'b0;
        settle();
        chk("jmp_pc_before", 32'(PC), 32'd0);
        repeat (3) step();
        chk("jmp_pc", 32'(PC), 32'h3FF);
        chk("jmp_estado", 32'(estado), 32'd0);
        OP     = 5'd0;
        PCflag = 2'b00;
        repeat (3) step();
        chk("wrap_pc", 32'(PC), 32'd0);
        OP     = 5'd30;                             // unknown opcode, flag 11
        PCflag = 2'b11;
        step();
        step();
        chk("nop_exec_writereg", 32'(writeReg), 32'd0);
        step();
        chk("nop_pc", 32'(PC), 32'd1);

        // ---------------- IN handshake ----------------
        OP          = 5'd24;
        PCflag      = 2'b00;
        writeReg_in = 1'b1;
        NZenable_in = 1'b1;
        step();
        step();
        chk("in_exec_estado", 32'(estado), 32'd2);
        chk("in_exec_writereg", 32'(writeReg), 32'd0);
        chk("in_exec_nzload", 32'(NZload), 32'd0);
        step();
        chk("in_wait_estado", 32'(estado), 32'd3);
        chk("in_wait_pronta", 32'(entrada_pronta), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("in_wait_pronta_n", 32'(entrada_pronta), 32'd1);
            chk("in_wait_writereg_n", 32'(writeReg), 32'd0);
            chk("in_wait_pc_n", 32'(PC), 32'd1);
        end
        entrada_valida = 1'b1;
        settle();
        chk("in_accept_writereg", 32'(writeReg), 32'd1);
        chk("in_accept_nzload", 32'(NZload), 32'd0);
        step();
        entrada_valida = 1'b0;
        writeReg_in    = 1'b0;
        NZenable_in    = 1'b0;
        settle();
        chk("in_done_estado", 32'(estado), 32'd0);
        chk("in_done_pc", 32'(PC), 32'd2);
        chk("in_done_writereg", 32'(writeReg), 32'd0);
        chk("in_done_pronta", 32'(entrada_pronta), 32'd0);

        // ---------------- OUT handshake ----------------
        OP               = 5'd25;
        writeRAMsaida_in = 1'b1;
        saida_ack        = 1'b1;
        pulseBase        = outPulses;
        step();
        step();
        chk("out_exec_wrsaida", 32'(writeRAMsaida), 32'd1);
        step();
        saida_ack = 1'b0;
        settle();
        chk("out_wait_estado", 32'(estado), 32'd4);
        chk("out_wait_pc", 32'(PC), 32'd2);
        chk("out_wait_wrsaida", 32'(writeRAMsaida), 32'd0);
        step();
        step();
        chk("out_wait2_estado", 32'(estado), 32'd4);
        saida_ack = 1'b1;
        step();
        saida_ack        = 1'b0;
        writeRAMsaida_in = 1'b0;
        settle();
        chk("out_done_estado", 32'(estado), 32'd0);
        chk("out_done_pc", 32'(PC), 32'd3);
        chk("out_pulse_count", 32'(outPulses - pulseBase), 32'd1);

        // ---------------- HLT ----------------
        OP     = 5'd23;
        PCflag = 2'b10;
        repeat (3) step();
        chk("hlt_estado", 32'(estado), 32'd5);
        chk("hlt_halted", 32'(halted), 32'd1);
        chk("hlt_pc", 32'(PC), 32'd3);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("hlt_pc_frozen", 32'(PC), 32'd3);
            chk("hlt_halted_n", 32'(halted), 32'd1);
            chk("hlt_irload_n", 32'(IRload), 32'd0);
        end
`ifdef SEQ_RESUME_EN
        continuar = 1'b1;
        step();
        continuar = 1'b0;
        settle();
        chk("resume_estado", 32'(estado), 32'd0);
        chk("resume_pc", 32'(PC), 32'd4);
        chk("resume_halted", 32'(halted), 32'd0);
        repeat (3) step();
        chk("rehlt_estado", 32'(estado), 32'd5);
`endif

        // ---------------- reset in PARADO ----------------
        reset = 1'b1;
        step();
        chk("rstp_estado", 32'(estado), 32'd0);
        chk("rstp_pc", 32'(PC), 32'd0);
        chk("rstp_halted", 32'(halted), 32'd0);
        chk("rstp_irload", 32'(IRload), 32'd0);

        // ---------------- reset in ESP_IN ----------------
        reset  = 1'b0;
        OP     = 5'd24;
        PCflag = 2'b00;
        repeat (3) step();
        chk("rsti_pre_estado", 32'(estado), 32'd3);
        entrada_valida = 1'b1;
        reset          = 1'b1;
        step();
        chk("rsti_estado", 32'(estado), 32'd0);
        chk("rsti_pc", 32'(PC), 32'd0);
        chk("rsti_writereg", 32'(writeReg), 32'd0);
        chk("rsti_pronta", 32'(entrada_pronta), 32'd0);
        reset          = 1'b0;
        entrada_valida = 1'b0;
        settle();
        chk("rsti_refetch_irload", 32'(IRload), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
